counter_hex_display: RTL and testbench

- Parametrised up/down binary counter with synchronous load, optional modulus, and wrap or saturate mode.
- Registered active-low seven-segment encoding of every hex nibble of the count.
- Next generation of the board-level counter-plus-display blocks: any width, any modulus, both directions, terminal-count flag.
- Sits between switch/key inputs and the HEXn displays on the lab board top level.

---
 rtl/counter_hex_display.sv | 149 ++++++++++++++
 tb/tb_counter_hex_display.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/counter_hex_display.sv
// counter_hex_display
//   Up/down binary counter with synchronous load, optional modulus and
//   wrap-or-saturate behaviour, plus a registered active-low seven-segment
//   encoding of every hex nibble of the count.
//
// Parameters
//   WIDTH    counter width in bits (1..32)
//   MODULUS  0 -> range 0..2^WIDTH-1, else range 0..MODULUS-1 (2..2^WIDTH)
//   WRAP     1 -> wrap at range ends, 0 -> saturate at range ends
//
// Ports
//   clk       in   rising-edge clock
//   aclr      in   synchronous active-high clear (highest priority)
//   en        in   count enable
//   up        in   1 = increment, 0 = decrement
//   load      in   synchronous load strobe (beats en)
//   load_val  in   [WIDTH-1:0] value to load, clamped to the range maximum
//   count     out  [WIDTH-1:0] registered count
//   tc        out  terminal count: the next enabled edge wraps or saturates
//   hex       out  [7*DIGITS-1:0] registered segments, digit k at
//                  hex[7k+6:7k], bit 7k+6 = segment a, bit 7k = segment g
//
// Build option
//   HEX_BLANK_EN  when defined, leading-zero digits above digit 0 are dark.

module counter_hex_display #(
  parameter int     WIDTH   = 16,
  parameter longint MODULUS = 0,
  parameter bit     WRAP    = 1'b1
) (
  input  logic                              clk,
  input  logic                              aclr,
  input  logic                              en,
  input  logic                              up,
  input  logic                              load,
  input  logic [WIDTH-1:0]                  load_val,
  output logic [WIDTH-1:0]                  count,
  output logic                              tc,
  output logic [7*((WIDTH+3)/4)-1:0]        hex
);

  localparam int DIGITS = (WIDTH + 3) / 4;

  // Range compare is done one bit wider than the counter so that
  // MODULUS = 2^WIDTH yields MAX = 2^WIDTH-1 without overflow.
  localparam logic [WIDTH:0] MAX_E = (MODULUS == 0) ? {1'b0, {WIDTH{1'b1}}}
                                                    : (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX   = MAX_E[WIDTH-1:0];
  localparam logic [WIDTH:0]   ONE_E = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONE   = ONE_E[WIDTH-1:0];

  logic [WIDTH-1:0]        count_q, count_d;
  logic [7*DIGITS-1:0]     hex_q, hex_d;
  logic [WIDTH:0]          count_e;
  logic [WIDTH:0]          inc_e;
  logic [WIDTH:0]          load_e;
  logic                    at_max;
  logic                    at_zero;

  // Active-low segment pattern for one nibble, order a..g (a is MSB).
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Encode the whole count; the top nibble is zero-extended when WIDTH
  // is not a multiple of four.
  function automatic logic [7*DIGITS-1:0] encode(input logic [WIDTH-1:0] v);
    logic [4*DIGITS-1:0] padded;
    logic [7*DIGITS-1:0] r;
    padded = '0;
    padded[WIDTH-1:0] = v;
    r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      r[7*k +: 7] = seg7(padded[4*k +: 4]);
`ifdef HEX_BLANK_EN
      // A digit goes dark when it and every digit above it are zero.
      if (k > 0 && (padded >> (4*k)) == '0) begin
        r[7*k +: 7] = 7'b1111111;
      end
`endif
    end
    return r;
  endfunction

  assign count_e = {1'b0, count_q};
  assign inc_e   = count_e + ONE_E;
  assign load_e  = {1'b0, load_val};
  assign at_max  = (count_e == MAX_E);
  assign at_zero = (count_q == '0);

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = (load_e > MAX_E) ? MAX : load_val;
    end else if (en) begin
      if (up) begin
        if (at_max) begin
          count_d = WRAP ? '0 : MAX;
        end else begin
          count_d = inc_e[WIDTH-1:0];
        end
      end else begin
        if (at_zero) begin
          count_d = WRAP ? MAX : '0;
        end else begin
          count_d = count_q - ONE;
        end
      end
    end
  end

  // Display tracks the post-update count so it never lags count.
  assign hex_d = encode(count_d);

  always_ff @(posedge clk) begin
    if (aclr) begin
      count_q <= '0;
      hex_q   <= encode('0);
    end else begin
      count_q <= count_d;
      hex_q   <= hex_d;
    end
  end

  // Clear and load both preempt counting, so no terminal event is pending.
  assign tc    = en & ~aclr & ~load & ((up & at_max) | (~up & at_zero));
  assign count = count_q;
  assign hex   = hex_q;

endmodule

// File: tb/tb_counter_hex_display.sv
module tb_counter_hex_display;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        aclr, en, up, load;
  logic [15:0] lv_a;
  logic [6:0]  lv_b;
  logic [15:0] cnt_a;
  logic        tc_a;
  logic [27:0] hex_a;
  logic [6:0]  cnt_b;
  logic        tc_b;
  logic [13:0] hex_b;

  // A: default build, full 16-bit range, wrapping.
  counter_hex_display #(.WIDTH(16), .MODULUS(0), .WRAP(1'b1)) u_a (
    .clk(clk), .aclr(aclr), .en(en), .up(up), .load(load),
    .load_val(lv_a), .count(cnt_a), .tc(tc_a), .hex(hex_a));

  // B: odd width, decimal modulus, saturating.
  counter_hex_display #(.WIDTH(7), .MODULUS(100), .WRAP(1'b0)) u_b (
    .clk(clk), .aclr(aclr), .en(en), .up(up), .load(load),
    .load_val(lv_b), .count(cnt_b), .tc(tc_b), .hex(hex_b));

  localparam logic [6:0] SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  typedef struct {
    longint cnt;
    longint tc;
    longint hex;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks   = 0;
  int   failures = 0;
  longint ma, mb;

  function automatic longint model_hex(longint c, int digits);
    longint r = 0;
    for (int k = 0; k < digits; k++) begin
      longint nib = (c >> (4*k)) & 15;
      longint seg = SEG[nib];
`ifdef HEX_BLANK_EN
      if (k > 0 && (c >> (4*k)) == 0) seg = 7'h7F;
`endif
      r = r | (seg << (7*k));
    end
    return r;
  endfunction

  function automatic longint model_next(longint c, longint mx, bit wrap,
                                        bit a, bit l, longint lv, bit e, bit u);
    if (a) return 0;
    if (l) return (lv > mx) ? mx : lv;
    if (!e) return c;
    if (u) return (c == mx) ? (wrap ? 0 : mx) : c + 1;
    return (c == 0) ? (wrap ? mx : 0) : c - 1;
  endfunction

  function automatic longint model_tc(longint c, longint mx, bit a, bit l, bit e, bit u);
    if (a || l || !e) return 0;
    return (u ? (c == mx) : (c == 0)) ? 1 : 0;
  endfunction

  task automatic chk(string name, longint got, longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, record what the next negedge must show,
  // then advance the model across the coming edge.
  task automatic step(bit a, bit l, bit e, bit u, longint la, longint lb);
    exp_t ea, eb;
    aclr = a; load = l; en = e; up = u;
    lv_a = 16'(la);
    lv_b = 7'(lb);
    ea.cnt = ma; ea.tc = model_tc(ma, 65535, a, l, e, u); ea.hex = model_hex(ma, 4);
    eb.cnt = mb; eb.tc = model_tc(mb, 99, a, l, e, u);    eb.hex = model_hex(mb, 2);
    q_a.push_back(ea);
    q_b.push_back(eb);
    ma = model_next(ma, 65535, 1'b1, a, l, la & 16'hFFFF, e, u);
    mb = model_next(mb, 99, 1'b0, a, l, lb & 7'h7F, e, u);
    @(posedge clk);
    #1;
  endtask

  // Monitor: each negedge the DUTs present a settled count/tc/hex.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        chk("a_count", longint'(cnt_a), e.cnt);
        chk("a_tc",    longint'(tc_a),  e.tc);
        chk("a_hex",   longint'(hex_a), e.hex);
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        chk("b_count", longint'(cnt_b), e.cnt);
        chk("b_tc",    longint'(tc_b),  e.tc);
        chk("b_hex",   longint'(hex_b), e.hex);
      end
    end
  end

  initial begin
    int r;
    bit a, l, e, u;
    longint la, lb;
    aclr = 1'b1; load = 1'b0; en = 1'b0; up = 1'b0; lv_a = '0; lv_b = '0;
    @(posedge clk);
    #1;
    ma = 0;
    mb = 0;

    // Reset state, then wrap of the full-range counter past 0xFFFF.
    step(0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 1, 'hFFFE, 50);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    // Load beats enable; B clamps an out-of-range load to 99 then saturates.
    step(0, 1, 1, 1, 'h1234, 120);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // Clear beats a simultaneous load and enable.
    step(1, 1, 1, 1, 'h555, 7);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 2000; i++) begin
      a = ($urandom_range(0, 59) == 0);
      l = ($urandom_range(0, 9) == 0);
      e = ($urandom_range(0, 3) != 0);
      u = $urandom_range(0, 1);
      r = $urandom_range(0, 3);
      la = (r == 0) ? 65535 - $urandom_range(0, 2) :
           (r == 1) ? $urandom_range(0, 2) : $urandom_range(0, 65535);
      r = $urandom_range(0, 3);
      lb = (r == 0) ? 98 + $urandom_range(0, 2) :
           (r == 1) ? $urandom_range(0, 2) : $urandom_range(0, 127);
      step(a, l, e, u, la, lb);
    end

    en = 1'b0; load = 1'b0; aclr = 1'b0;
    for (int i = 0; i < 10 && (q_a.size() > 0 || q_b.size() > 0); i++) begin
      @(posedge clk);
    end
    if (q_a.size() > 0 || q_b.size() > 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0 pending entries", q_a.size() + q_b.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
